// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the execute-stage ALU.
//   - alu_op group codes and funct codes
//   - internal operation enum produced by alu_op_decode
//   - FSM state enum for the iterative multiply/divide sequencer
package alu_pkg;

  // alu_op groups
  localparam logic [1:0] AluOpImm    = 2'b00;
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpRtype  = 2'b10;
  localparam logic [1:0] AluOpLui    = 2'b11;

  // funct codes (the immediate group reuses add/and/or/xor)
  localparam logic [5:0] FunctAddu  = 6'b100001;
  localparam logic [5:0] FunctSubu  = 6'b100011;
  localparam logic [5:0] FunctAnd   = 6'b100100;
  localparam logic [5:0] FunctOr    = 6'b100101;
  localparam logic [5:0] FunctXor   = 6'b100110;
  localparam logic [5:0] FunctNor   = 6'b100111;
  localparam logic [5:0] FunctSlt   = 6'b101010;
  localparam logic [5:0] FunctSltu  = 6'b101011;
  localparam logic [5:0] FunctSll   = 6'b000000;
  localparam logic [5:0] FunctSrl   = 6'b000010;
  localparam logic [5:0] FunctSra   = 6'b000011;
  localparam logic [5:0] FunctMfhi  = 6'b010000;
  localparam logic [5:0] FunctMthi  = 6'b010001;
  localparam logic [5:0] FunctMflo  = 6'b010010;
  localparam logic [5:0] FunctMtlo  = 6'b010011;
  localparam logic [5:0] FunctMult  = 6'b011000;
  localparam logic [5:0] FunctMultu = 6'b011001;
  localparam logic [5:0] FunctDiv   = 6'b011010;
  localparam logic [5:0] FunctDivu  = 6'b011011;

  typedef enum logic [4:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSlt, OpSltu, OpSll, OpSrl, OpSra, OpLui,
    OpMfhi, OpMflo, OpMthi, OpMtlo, OpMult, OpMultu, OpDiv, OpDivu, OpNop
  } alu_op_e;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  function automatic logic is_mul(input alu_op_e op);
    return (op == OpMult) || (op == OpMultu);
  endfunction

  function automatic logic is_div(input alu_op_e op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  function automatic logic is_signed_md(input alu_op_e op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational map from alu_op/funct to the internal operation.
//   alu_op  in  2  operation group
//   funct   in  6  function code
//   op      out    internal operation (OpNop for any unlisted code)
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output alu_op_e    op
);

  always_comb begin
    op = OpNop;
    unique case (alu_op)
      AluOpImm: begin
        case (funct)
          FunctAddu: op = OpAdd;
          FunctOr:   op = OpOr;
          FunctAnd:  op = OpAnd;
          FunctXor:  op = OpXor;
          default:   op = OpNop;
        endcase
      end
      AluOpBranch: op = OpSub;
      AluOpLui:    op = OpLui;
      AluOpRtype: begin
        case (funct)
          FunctAddu:  op = OpAdd;
          FunctSubu:  op = OpSub;
          FunctAnd:   op = OpAnd;
          FunctOr:    op = OpOr;
          FunctXor:   op = OpXor;
          FunctNor:   op = OpNor;
          FunctSlt:   op = OpSlt;
          FunctSltu:  op = OpSltu;
          FunctSll:   op = OpSll;
          FunctSrl:   op = OpSrl;
          FunctSra:   op = OpSra;
          FunctMfhi:  op = OpMfhi;
          FunctMflo:  op = OpMflo;
          FunctMthi:  op = OpMthi;
          FunctMtlo:  op = OpMtlo;
          FunctMult:  op = OpMult;
          FunctMultu: op = OpMultu;
          FunctDiv:   op = OpDiv;
          FunctDivu:  op = OpDivu;
          default:    op = OpNop;
        endcase
      end
      default: op = OpNop;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute-stage ALU with iterative multiply/divide and HI/LO.
//   clk, rst           clock and synchronous active-high reset
//   in_valid/in_ready  operation handshake; transfer on in_valid & in_ready
//   alu_op, funct      operation select
//   src_a, src_b       operands (src_b is the extended immediate for I-type)
//   shamt              shift amount; shifts operate on src_b (the rt operand)
//   out_valid          one-cycle pulse qualifying result/zero
//   result, zero       registered result and result==0 flag
//   busy               multiply/divide iterating
//   hi, lo             architectural HI/LO
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [SHW:0] LastIter = (SHW+1)'(WIDTH - 1);

  alu_op_e op;
  state_e  state_q, state_d;

  logic               accept, start_mul, start_div;
  logic [WIDTH-1:0]   hi_q, lo_q, result_q;
  logic               zero_q, out_valid_q;
  logic [WIDTH-1:0]   sc_result;

  // Iteration state: for multiply acc = {partial product, multiplier},
  // for divide acc = {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic               neg_q, rem_neg_q, dz_q;
  logic [SHW:0]       cnt_q;
  logic               iterating, last_iter;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fin_hi, fin_lo;

  alu_op_decode u_decode (
    .alu_op (alu_op),
    .funct  (funct),
    .op     (op)
  );

  assign accept    = in_valid & in_ready;
  assign start_mul = accept & is_mul(op);
  assign start_div = accept & is_div(op);
  assign iterating = (state_q == StMul) || (state_q == StDiv);
  assign last_iter = iterating && (cnt_q == LastIter);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_mul) begin
          state_d = StMul;
        end else if (start_div) begin
          state_d = StDiv;
        end else begin
          state_d = StIdle;
        end
      end
      StMul, StDiv: begin
        if (last_iter) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      StIdle, StDone: in_ready = 1'b1;
      StMul, StDiv:   busy     = 1'b1;
      default:        in_ready = 1'b0;
    endcase
  end

  // ---------------- Single-cycle datapath ----------------
  always_comb begin
    sc_result = '0;
    case (op)
      OpAdd:  sc_result = src_a + src_b;
      OpSub:  sc_result = src_a - src_b;
      OpAnd:  sc_result = src_a & src_b;
      OpOr:   sc_result = src_a | src_b;
      OpXor:  sc_result = src_a ^ src_b;
      OpNor:  sc_result = ~(src_a | src_b);
      OpSlt:  sc_result = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OpSltu: sc_result = {{(WIDTH-1){1'b0}}, src_a < src_b};
      OpSll:  sc_result = src_b << shamt;
      OpSrl:  sc_result = src_b >> shamt;
      OpSra:  sc_result = $signed(src_b) >>> shamt;
      OpLui:  sc_result = src_b << (WIDTH/2);
      OpMfhi: sc_result = hi_q;
      OpMflo: sc_result = lo_q;
      default: sc_result = '0;
    endcase
  end

  // ---------------- Multiply/divide iteration ----------------
  always_comb begin
    a_neg = is_signed_md(op) & src_a[WIDTH-1];
    b_neg = is_signed_md(op) & src_b[WIDTH-1];
    a_mag = a_neg ? -src_a : src_a;
    b_mag = b_neg ? -src_b : src_b;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    // Only used when div_shift >= divisor, where the difference fits in WIDTH bits.
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    acc_step  = acc_q;
    if (state_q == StMul) begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (state_q == StDiv) begin
      if (div_shift >= {1'b0, opnd_q}) begin
        acc_step = {div_diff, acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up on the final magnitude result. Signed MIN/-1 needs no special case:
  // |MIN|/1 = MIN, and negating MIN wraps back to MIN with a zero remainder.
  always_comb begin
    prod_fix = neg_q ? -acc_step : acc_step;
    quo_fix  = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_fix  = rem_neg_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    if (state_q == StMul) begin
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
      fin_lo = prod_fix[WIDTH-1:0];
    end else if (dz_q) begin
      fin_hi = a_raw_q;
      fin_lo = '1;
    end else begin
      fin_hi = rem_fix;
      fin_lo = quo_fix;
    end
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      opnd_q      <= '0;
      a_raw_q     <= '0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      dz_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (iterating) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 1'b1;
        if (last_iter) begin
          hi_q        <= fin_hi;
          lo_q        <= fin_lo;
          result_q    <= fin_lo;
          zero_q      <= (fin_lo == '0);
          out_valid_q <= 1'b1;
        end
      end else if (start_mul || start_div) begin
        acc_q     <= {{WIDTH{1'b0}}, start_mul ? b_mag : a_mag};
        opnd_q    <= start_mul ? a_mag : b_mag;
        a_raw_q   <= src_a;
        neg_q     <= a_neg ^ b_neg;
        rem_neg_q <= start_div & a_neg;
        dz_q      <= start_div & (src_b == '0);
        cnt_q     <= '0;
      end else if (accept) begin
        result_q    <= sc_result;
        zero_q      <= (sc_result == '0);
        out_valid_q <= 1'b1;
        if (op == OpMthi) hi_q <= src_a;
        if (op == OpMtlo) lo_q <= src_a;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: self-checking bench for alu_exec_unit (WIDTH 32 and WIDTH 16 instances).
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid, in_ready, out_valid, zero, busy;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b, result, hi, lo;
  logic [4:0]  shamt;

  // 16-bit instance
  logic        w_in_valid, w_in_ready, w_out_valid, w_zero, w_busy;
  logic [1:0]  w_alu_op;
  logic [5:0]  w_funct;
  logic [15:0] w_src_a, w_src_b, w_result, w_hi, w_lo;
  logic [3:0]  w_shamt;

  int n_vec = 0;
  int n_err = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .funct(funct), .src_a(src_a), .src_b(src_b), .shamt(shamt), .out_valid(out_valid),
    .result(result), .zero(zero), .busy(busy), .hi(hi), .lo(lo)
  );

  alu_exec_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .alu_op(w_alu_op),
    .funct(w_funct), .src_a(w_src_a), .src_b(w_src_b), .shamt(w_shamt),
    .out_valid(w_out_valid), .result(w_result), .zero(w_zero), .busy(w_busy), .hi(w_hi),
    .lo(w_lo)
  );

  // ---------------- Reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [1:0] aop, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh, input logic [31:0] h,
                                          input logic [31:0] l);
    int sa, sb;
    sa = a;
    sb = b;
    if (aop == 2'b01) return a - b;
    if (aop == 2'b11) return b * 32'h0001_0000;
    if (aop == 2'b00) begin
      case (fn)
        6'b100001: return a + b;
        6'b100101: return a | b;
        6'b100100: return a & b;
        6'b100110: return a ^ b;
        default:   return 32'd0;
      endcase
    end
    case (fn)
      6'b100001: return a + b;
      6'b100011: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b101010: return (sa < sb) ? 32'd1 : 32'd0;
      6'b101011: return (a < b) ? 32'd1 : 32'd0;
      6'b000000: return b * (32'd1 << sh);
      6'b000010: return b / (32'd1 << sh);
      6'b000011: return sb >>> sh;
      6'b010000: return h;
      6'b010010: return l;
      default:   return 32'd0;
    endcase
  endfunction

  task automatic ref_muldiv(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] rh, output logic [31:0] rl);
    longint p;
    logic [63:0] up;
    int sa, sb;
    sa = a;
    sb = b;
    case (fn)
      6'b011000: begin
        p = longint'(sa) * longint'(sb);
        {rh, rl} = p;
      end
      6'b011001: begin
        up = {32'd0, a} * {32'd0, b};
        {rh, rl} = up;
      end
      default: begin
        if (b == 32'd0) begin
          rl = 32'hFFFF_FFFF;
          rh = a;
        end else if (fn == 6'b011010) begin
          if (sa == 32'sh8000_0000 && sb == -1) begin
            rl = 32'h8000_0000;
            rh = 32'd0;
          end else begin
            rl = sa / sb;
            rh = sa % sb;
          end
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
    endcase
  endtask

  // Called at a negedge; presents the op, waits for in_ready (bounded), and returns at the
  // negedge of the cycle after the transfer.
  task automatic issue(input logic [1:0] aop, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    alu_op   = aop;
    funct    = fn;
    src_a    = a;
    src_b    = b;
    shamt    = sh;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (guard >= 200) begin
      $display("FAIL issue_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
      n_err++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec += 7;
    if (in_ready !== 1'b1) begin $display("FAIL rst_in_ready: got %0b want 1", in_ready); n_err++; end
    if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid: got %0b want 0", out_valid); n_err++; end
    if (result !== 32'd0) begin $display("FAIL rst_result: got %h want 0", result); n_err++; end
    if (zero !== 1'b1) begin $display("FAIL rst_zero: got %0b want 1", zero); n_err++; end
    if (busy !== 1'b0) begin $display("FAIL rst_busy: got %0b want 0", busy); n_err++; end
    if (hi !== 32'd0) begin $display("FAIL rst_hi: got %h want 0", hi); n_err++; end
    if (lo !== 32'd0) begin $display("FAIL rst_lo: got %h want 0", lo); n_err++; end
    rst = 1'b0;
  endtask

  task automatic test_addu_subu();
    issue(2'b10, 6'b100001, 32'd5, 32'd7, 5'd0);
    n_vec += 3;
    if (out_valid !== 1'b1) begin $display("FAIL addu_valid: got %0b want 1", out_valid); n_err++; end
    if (result !== 32'd12) begin $display("FAIL addu_result: got %h want 0000000c", result); n_err++; end
    if (zero !== 1'b0) begin $display("FAIL addu_zero: got %0b want 0", zero); n_err++; end
    issue(2'b10, 6'b100011, 32'd5, 32'd5, 5'd0);
    n_vec += 2;
    if (result !== 32'd0) begin $display("FAIL subu_result: got %h want 0", result); n_err++; end
    if (zero !== 1'b1) begin $display("FAIL subu_zero: got %0b want 1", zero); n_err++; end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin $display("FAIL idle_valid: got %0b want 0", out_valid); n_err++; end
  endtask

  task automatic test_compare_shift();
    issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0);
    n_vec++;
    if (result !== 32'd1) begin $display("FAIL slt: got %h want 1", result); n_err++; end
    issue(2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1, 5'd0);
    n_vec++;
    if (result !== 32'd0) begin $display("FAIL sltu: got %h want 0", result); n_err++; end
    issue(2'b10, 6'b000011, 32'd0, 32'h8000_0000, 5'd4);
    n_vec++;
    if (result !== 32'hF800_0000) begin $display("FAIL sra: got %h want f8000000", result); n_err++; end
    issue(2'b10, 6'b000010, 32'd0, 32'h8000_0000, 5'd4);
    n_vec++;
    if (result !== 32'h0800_0000) begin $display("FAIL srl: got %h want 08000000", result); n_err++; end
    issue(2'b11, 6'b000000, 32'd0, 32'h0000_1234, 5'd0);
    n_vec++;
    if (result !== 32'h1234_0000) begin $display("FAIL lui: got %h want 12340000", result); n_err++; end
  endtask

  // Random single-cycle ops held back-to-back; out_valid must stay high throughout.
  task automatic test_back_to_back();
    logic [5:0]  imm_codes[5] = '{6'b100001, 6'b100101, 6'b100100, 6'b100110, 6'b111000};
    logic [5:0]  r_codes[18]  = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
                                  6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                                  6'b000011, 6'b010000, 6'b010010, 6'b010001, 6'b010011,
                                  6'b111111, 6'b000001, 6'b101000};
    logic [31:0] m_hi, m_lo, exp_r, a, b;
    logic [1:0]  aop;
    logic [5:0]  fn;
    logic [4:0]  sh;
    m_hi = hi;
    m_lo = lo;
    in_valid = 1'b1;
    for (int i = 0; i < 150; i++) begin
      aop = 2'($urandom_range(0, 3));
      fn  = (aop == 2'b00) ? imm_codes[$urandom_range(0, 4)] : r_codes[$urandom_range(0, 17)];
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      sh  = 5'($urandom);
      alu_op = aop; funct = fn; src_a = a; src_b = b; shamt = sh;
      exp_r = ref_alu(aop, fn, a, b, sh, m_hi, m_lo);
      if (aop == 2'b10 && fn == 6'b010001) m_hi = a;
      if (aop == 2'b10 && fn == 6'b010011) m_lo = a;
      @(negedge clk);
      n_vec += 5;
      if (out_valid !== 1'b1) begin $display("FAIL b2b_valid[%0d]: got %0b want 1", i, out_valid); n_err++; end
      if (result !== exp_r) begin
        $display("FAIL b2b_result[%0d] op=%0d fn=%b: got %h want %h", i, aop, fn, result, exp_r);
        n_err++;
      end
      if (zero !== (exp_r == 32'd0)) begin $display("FAIL b2b_zero[%0d]: got %0b want %0b", i, zero, exp_r == 32'd0); n_err++; end
      if (hi !== m_hi) begin $display("FAIL b2b_hi[%0d]: got %h want %h", i, hi, m_hi); n_err++; end
      if (lo !== m_lo) begin $display("FAIL b2b_lo[%0d]: got %h want %h", i, lo, m_lo); n_err++; end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Issues a mult/div, counts busy cycles and checks the DONE cycle against the model.
  task automatic run_muldiv(input string tag, input logic [5:0] fn, input logic [31:0] a,
                            input logic [31:0] b);
    logic [31:0] eh, el;
    int busy_n, bad_ready, early;
    ref_muldiv(fn, a, b, eh, el);
    issue(2'b10, fn, a, b, 5'd0);
    busy_n = 0; bad_ready = 0; early = 0;
    while (busy && busy_n < 100) begin
      if (in_ready) bad_ready++;
      if (out_valid) early++;
      busy_n++;
      @(negedge clk);
    end
    n_vec += 7;
    if (busy_n != 32) begin $display("FAIL %s_busy_cycles: got %0d want 32", tag, busy_n); n_err++; end
    if (bad_ready != 0 || early != 0) begin
      $display("FAIL %s_stall: in_ready high %0d, out_valid high %0d cycles, want 0", tag, bad_ready, early);
      n_err++;
    end
    if (out_valid !== 1'b1) begin $display("FAIL %s_done_valid: got %0b want 1", tag, out_valid); n_err++; end
    if (in_ready !== 1'b1) begin $display("FAIL %s_done_ready: got %0b want 1", tag, in_ready); n_err++; end
    if (hi !== eh) begin $display("FAIL %s_hi: a=%h b=%h got %h want %h", tag, a, b, hi, eh); n_err++; end
    if (lo !== el) begin $display("FAIL %s_lo: a=%h b=%h got %h want %h", tag, a, b, lo, el); n_err++; end
    if (result !== el) begin $display("FAIL %s_result: got %h want %h", tag, result, el); n_err++; end
  endtask

  task automatic test_mult();
    run_muldiv("mult", 6'b011000, 32'hFFFF_FFFD, 32'd7);
    n_vec += 2;
    if (hi !== 32'hFFFF_FFFF) begin $display("FAIL mult_hi_const: got %h want ffffffff", hi); n_err++; end
    if (lo !== 32'hFFFF_FFEB) begin $display("FAIL mult_lo_const: got %h want ffffffeb", lo); n_err++; end
    // mflo accepted in the DONE cycle
    issue(2'b10, 6'b010010, 32'd0, 32'd0, 5'd0);
    n_vec++;
    if (result !== 32'hFFFF_FFEB) begin $display("FAIL mflo_after_mult: got %h want ffffffeb", result); n_err++; end
    issue(2'b10, 6'b010000, 32'd0, 32'd0, 5'd0);
    n_vec++;
    if (result !== 32'hFFFF_FFFF) begin $display("FAIL mfhi_after_mult: got %h want ffffffff", result); n_err++; end
  endtask

  task automatic test_div();
    run_muldiv("div", 6'b011010, 32'hFFFF_FFF9, 32'd2);
    n_vec += 2;
    if (lo !== 32'hFFFF_FFFD) begin $display("FAIL div_lo_const: got %h want fffffffd", lo); n_err++; end
    if (hi !== 32'hFFFF_FFFF) begin $display("FAIL div_hi_const: got %h want ffffffff", hi); n_err++; end
    run_muldiv("divu0", 6'b011011, 32'd9, 32'd0);
    n_vec += 2;
    if (lo !== 32'hFFFF_FFFF) begin $display("FAIL divu0_lo_const: got %h want ffffffff", lo); n_err++; end
    if (hi !== 32'd9) begin $display("FAIL divu0_hi_const: got %h want 9", hi); n_err++; end
    run_muldiv("div0", 6'b011010, 32'hFFFF_FFF7, 32'd0);
    run_muldiv("divmin", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_muldiv("divneg", 6'b011010, 32'd100, 32'hFFFF_FFF9);
  endtask

  task automatic test_random_muldiv();
    logic [5:0]  fn;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      fn = 6'b011000 | 6'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 4 == 3) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i % 3 == 1) b = {{16{b[15]}}, b[15:0]};
      run_muldiv("rand_md", fn, a, b);
    end
  endtask

  task automatic test_abort();
    int stray;
    test_reset();
    @(negedge clk);
    issue(2'b10, 6'b011011, 32'd1000, 32'd7, 5'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec += 5;
    if (hi !== 32'd0) begin $display("FAIL abort_hi: got %h want 0", hi); n_err++; end
    if (lo !== 32'd0) begin $display("FAIL abort_lo: got %h want 0", lo); n_err++; end
    if (in_ready !== 1'b1) begin $display("FAIL abort_ready: got %0b want 1", in_ready); n_err++; end
    if (busy !== 1'b0) begin $display("FAIL abort_busy: got %0b want 0", busy); n_err++; end
    if (out_valid !== 1'b0) begin $display("FAIL abort_valid: got %0b want 0", out_valid); n_err++; end
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || hi != 32'd0 || lo != 32'd0) stray++;
    end
    n_vec++;
    if (stray != 0) begin $display("FAIL abort_stray: got %0d cycles with activity want 0", stray); n_err++; end
  endtask

  // An addu held during busy must transfer only in DONE.
  task automatic test_stall();
    logic [31:0] eh, el, a, b, x, y;
    int guard, early;
    a = $urandom; b = $urandom; x = $urandom; y = $urandom;
    ref_muldiv(6'b011001, a, b, eh, el);
    issue(2'b10, 6'b011001, a, b, 5'd0);
    in_valid = 1'b1; alu_op = 2'b10; funct = 6'b100001; src_a = x; src_b = y;
    guard = 0; early = 0;
    while (!in_ready && guard < 100) begin
      if (out_valid) early++;
      guard++;
      @(negedge clk);
    end
    n_vec += 4;
    if (guard != 32 || early != 0) begin
      $display("FAIL stall_wait: got %0d busy cycles and %0d early pulses, want 32 and 0", guard, early);
      n_err++;
    end
    if (out_valid !== 1'b1) begin $display("FAIL stall_done_valid: got %0b want 1", out_valid); n_err++; end
    if (result !== el) begin $display("FAIL stall_done_result: got %h want %h", result, el); n_err++; end
    if (hi !== eh) begin $display("FAIL stall_done_hi: got %h want %h", hi, eh); n_err++; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_vec += 2;
    if (out_valid !== 1'b1) begin $display("FAIL stall_addu_valid: got %0b want 1", out_valid); n_err++; end
    if (result !== x + y) begin $display("FAIL stall_addu_result: got %h want %h", result, x + y); n_err++; end
  endtask

  task automatic test_width16();
    int busy_n;
    w_in_valid = 1'b1; w_alu_op = 2'b10; w_funct = 6'b011001;
    w_src_a = 16'hFFFF; w_src_b = 16'hFFFF;
    @(posedge clk);
    #1 w_in_valid = 1'b0;
    @(negedge clk);
    busy_n = 0;
    while (w_busy && busy_n < 100) begin
      busy_n++;
      @(negedge clk);
    end
    n_vec += 4;
    if (busy_n != 16) begin $display("FAIL w16_busy_cycles: got %0d want 16", busy_n); n_err++; end
    if (w_out_valid !== 1'b1) begin $display("FAIL w16_done_valid: got %0b want 1", w_out_valid); n_err++; end
    if (w_hi !== 16'hFFFE) begin $display("FAIL w16_hi: got %h want fffe", w_hi); n_err++; end
    if (w_lo !== 16'h0001) begin $display("FAIL w16_lo: got %h want 0001", w_lo); n_err++; end
    w_in_valid = 1'b1; w_alu_op = 2'b11; w_funct = 6'b000000;
    w_src_a = 16'h0000; w_src_b = 16'h00AB;
    @(posedge clk);
    #1 w_in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (w_result !== 16'hAB00) begin $display("FAIL w16_lui: got %h want ab00", w_result); n_err++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; alu_op = 2'b00; funct = 6'd0; src_a = '0; src_b = '0; shamt = '0;
    w_in_valid = 1'b0; w_alu_op = 2'b00; w_funct = 6'd0; w_src_a = '0; w_src_b = '0;
    w_shamt = '0;
    @(negedge clk);
    test_reset();
    test_addu_subu();
    test_compare_shift();
    test_back_to_back();
    test_mult();
    test_div();
    test_random_muldiv();
    test_abort();
    test_stall();
    test_width16();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
